// File: rtl/lo_sequencer.sv
// rtl/lo_sequencer.sv - command sequencer driving an attached combinational logic ALU
module lo_sequencer #(
  parameter int bits = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ_VALID,
  output logic            REQ_READY,
  input  logic [4:0]      REQ_OP,
  input  logic [bits-1:0] REQ_A,
  input  logic [bits-1:0] REQ_B,
  input  logic [3:0]      REQ_CNT,
  output logic [bits-1:0] ALU_A,
  output logic [bits-1:0] ALU_B,
  output logic [4:0]      ALU_OP,
  input  logic [bits-1:0] ALU_RESU,
  input  logic            ALU_C,
  input  logic            ALU_S,
  input  logic            ALU_Z,
  output logic            RSP_VALID,
  input  logic            RSP_READY,
  output logic [bits-1:0] RSP_RESU,
  output logic            RSP_C,
  output logic            RSP_S,
  output logic            RSP_Z,
  output logic            RSP_ERR,
  output logic            BUSY
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [4:0] OP_SHL   = 5'b01000;
  localparam logic [4:0] OP_SHR   = 5'b01001;
  localparam logic [4:0] OP_CLR   = 5'b10000;
  localparam logic [4:0] OP_PASSA = 5'b10101;
  localparam logic [4:0] OP_NOZS1 = 5'b10011;
  localparam logic [4:0] OP_NOZS2 = 5'b11111;

  logic [1:0]      state;
  logic [4:0]      op_r;
  logic [bits-1:0] res_r;
  logic [bits-1:0] b_r;
  logic [3:0]      cnt_r;
  logic            c_r;
  logic            s_r;
  logic            z_r;
  logic            err_r;

  logic            req_legal;
  logic            is_shift;
  logic            last_exec;
  logic            hold_zs;
  logic            hold_s;

  // Opcode decode for the incoming command and the latched working opcode
  always_comb begin
    req_legal = (REQ_OP == OP_SHL) || (REQ_OP == OP_SHR) || REQ_OP[4];
    is_shift  = (op_r == OP_SHL) || (op_r == OP_SHR);
    // A shift stays in EXEC until its remaining count is about to hit zero;
    // a zero-count shift and every other opcode take a single cycle.
    last_exec = !is_shift || (cnt_r <= 4'd1);
    hold_zs   = (op_r == OP_NOZS1) || (op_r == OP_NOZS2);
    hold_s    = hold_zs || (op_r == OP_CLR);
  end

  // Command FSM, working registers and the persistent flag register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      op_r  <= OP_CLR;
      res_r <= '0;
      b_r   <= '0;
      cnt_r <= 4'd0;
      c_r   <= 1'b0;
      s_r   <= 1'b0;
      z_r   <= 1'b0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            op_r  <= REQ_OP;
            b_r   <= REQ_B;
            cnt_r <= REQ_CNT;
            if (req_legal) begin
              res_r <= REQ_A;
              err_r <= 1'b0;
              state <= EXEC;
            end else begin
              // Illegal opcodes skip the ALU entirely and leave flags alone
              res_r <= '0;
              err_r <= 1'b1;
              state <= DONE;
            end
          end
        end
        EXEC: begin
          res_r <= ALU_RESU;
          if (is_shift && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
          end
          if (last_exec) begin
            if (is_shift) begin
              // Zero-count shift runs as pass-A, which has no carry out
              c_r <= (cnt_r == 4'd0) ? 1'b0 : ALU_C;
            end
            if (!hold_zs) begin
              z_r <= ALU_Z;
            end
            if (!hold_s) begin
              s_r <= ALU_S;
            end
            state <= DONE;
          end
        end
        DONE: begin
          if (RSP_READY) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive and response outputs; the ALU sees a benign clear op outside EXEC
  always_comb begin
    ALU_OP = OP_CLR;
    ALU_A  = '0;
    ALU_B  = '0;
    if (state == EXEC) begin
      ALU_A  = res_r;
      ALU_B  = b_r;
      ALU_OP = (is_shift && (cnt_r == 4'd0)) ? OP_PASSA : op_r;
    end
    REQ_READY = (state == IDLE) && !RST;
    RSP_VALID = (state == DONE);
    BUSY      = (state != IDLE);
    RSP_RESU  = res_r;
    RSP_C     = c_r;
    RSP_S     = s_r;
    RSP_Z     = z_r;
    RSP_ERR   = err_r;
  end

endmodule

// File: doc/lo_sequencer.md
LO_SEQUENCER -- requirements
Module: lo_sequencer

Interface
REQ-001 SHALL have parameter: bits, default 16, datapath width shared with the attached logic ALU.
REQ-002 SHALL have ports (name  direction  width  meaning):
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  command valid.
- REQ_READY  out  1  command accepted when both REQ_VALID and REQ_READY are high at a CLK edge.
- REQ_OP  in  5  logic-ALU opcode.
- REQ_A, REQ_B  in  bits  operands.
- REQ_CNT  in  4  shift repeat count; used only for opcodes 01000 and 01001.
- ALU_A, ALU_B  out  bits  operands driven to the logic ALU.
- ALU_OP  out  5  opcode driven to the logic ALU.
- ALU_RESU  in  bits  ALU result, combinational.
- ALU_C, ALU_S, ALU_Z  in  1  ALU flags, combinational.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  response consumed when both RSP_VALID and RSP_READY are high at a CLK edge.
- RSP_RESU  out  bits  final result.
- RSP_C, RSP_S, RSP_Z  out  1  flag register contents.
- RSP_ERR  out  1  illegal opcode.
- BUSY  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-004 REQ_READY SHALL be 1 only in IDLE; on accept, latch REQ_OP, REQ_A, REQ_B, REQ_CNT into working registers and go to EXEC.
REQ-005 Legal opcodes SHALL be 01000, 01001 and 10000..11111; every other opcode is illegal.
REQ-006 Illegal opcode: no EXEC cycle; DONE on the next edge with RSP_RESU=0 and RSP_ERR=1; flags unchanged.
REQ-007 In IDLE and DONE, ALU_OP SHALL be 10000 and ALU_A and ALU_B SHALL be 0.
REQ-008 In EXEC, ALU_A SHALL be the working result register (initially REQ_A), ALU_B the latched B, and ALU_OP the latched opcode.
REQ-009 Non-shift legal opcode: exactly 1 EXEC cycle; capture ALU_RESU into the result register; go to DONE.
- RSP_VALID rises 2 edges after accept.
REQ-010 Shift opcode with REQ_CNT=n>0: n EXEC cycles.
- Each cycle, ALU_RESU is written back to the working register, so ALU_A carries the previous iteration's result.
- Decrement a remaining-count register each cycle; leave EXEC when it reaches 0.
- RSP_VALID rises n+1 edges after accept.
REQ-011 Shift opcode with REQ_CNT=0: 1 EXEC cycle with ALU_OP forced to 10101 (pass A).
- Result is A; C cleared to 0; Z and S taken from the ALU.
REQ-012 Flag register C SHALL update only on the last EXEC cycle of a shift opcode, from ALU_C; otherwise it holds.
REQ-013 Flag register Z SHALL update from ALU_Z on the last EXEC cycle, except for opcodes 10011 and 11111, where it holds.
REQ-014 Flag register S SHALL update from ALU_S on the last EXEC cycle, except for opcodes 10011, 11111 and 10000, where it holds.
REQ-015 Flag register SHALL persist across commands; it changes only as REQ-012..014 state, or on reset.
REQ-016 In DONE, RSP_VALID=1 and RSP_RESU, RSP_ERR and the flags SHALL stay stable until the RSP handshake.
- On the handshake edge go to IDLE; REQ_READY is 1 the following cycle.
REQ-017 RSP_ERR SHALL clear on the next accepted command.
REQ-018 REQ_VALID in EXEC or DONE SHALL be ignored (no accept, no state effect).
REQ-019 Result and operand registers SHALL be bits wide; the count register SHALL be 4 bits with no wrap.

Reset
REQ-020 While RST=1, all registers SHALL clear immediately, asynchronously:
- state IDLE, result 0, flags C=S=Z=0, RSP_ERR=0, remaining count 0.
REQ-021 While RST=1, outputs SHALL be REQ_READY=0, RSP_VALID=0, BUSY=0, ALU_OP=10000, ALU_A=ALU_B=0.
REQ-022 Reset asserted mid-EXEC or mid-DONE SHALL abort the command with no response.
- REQ_READY=1 on the first cycle after RST deasserts.

Verification (bits=8, real logic ALU attached)
REQ-023 The bench SHALL cover the following scenarios:
- AND: op 10001, A=F0, B=3C -> RSP_RESU=30, Z=0, S=0, RSP_VALID 2 edges after accept.
- Shift: op 01000, A=91, CNT=3 -> ALU_A sequence 91, 22, 44; RSP_RESU=88, C=0, S=1, Z=0; RSP_VALID 4 edges after accept.
- Sticky flags: after the AND case, op 10011, B=00 -> RSP_RESU=00, Z and S unchanged (0, 0), C unchanged.
- Illegal: op 00101 -> RSP_ERR=1, RSP_RESU=00, flags unchanged, ALU_OP never leaves 10000.
- Backpressure: RSP_READY=0 for 5 cycles in DONE -> outputs stable, REQ_READY=0, BUSY=1; accept in IDLE the cycle after the handshake.
- Reset mid-run: op 01001, CNT=15, RST pulsed at EXEC cycle 3 -> all outputs per REQ-021, no RSP_VALID, REQ_READY=1 the cycle after release.
